bcd_run_ctrl: RTL and testbench

BCD_RUN_CTRL -- requirements
Module: bcd_run_ctrl

---
 rtl/bcd_run_ctrl.sv | 161 ++++++++++++++++
 tb/tb_bcd_run_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/bcd_run_ctrl.sv
// Four-digit packed-BCD run controller: prescaled up/down counting with start/stop/clear/load.
// Optional lap capture register enabled by defining BCD_RUN_CTRL_LAP_EN.
module bcd_run_ctrl #(
    parameter int TICK_DIV = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic        i_stop,
    input  logic        i_clear,
    input  logic        i_load,
    input  logic [15:0] i_load_val,
    input  logic        i_up_dn,
    input  logic        i_lap,
    output logic [15:0] o_count,
    output logic [1:0]  o_state,
    output logic        o_running,
    output logic        o_done,
    output logic [15:0] o_lap_val
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_t;

    localparam logic [7:0] PRESC_MAX = 8'(TICK_DIV - 1);

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (v[4*i +: 4] >= 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [15:0] r;
        logic        b;
        r = v;
        b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (b) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    b = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [15:0] bcd_sat(input logic [15:0] v);
        logic [15:0] r;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = (v[4*i +: 4] > 4'd9) ? 4'd9 : v[4*i +: 4];
        end
        return r;
    endfunction

    state_t      r_state, w_state_nxt;
    logic [15:0] r_count, w_count_nxt;
    logic [7:0]  r_presc, w_presc_nxt;
    logic        r_running, r_done, w_done_nxt;
    logic [15:0] r_lap_val, w_lap_nxt;
    logic [15:0] w_term, w_step_val;

    assign w_term     = i_up_dn ? 16'h9999 : 16'h0000;
    assign w_step_val = i_up_dn ? bcd_inc(r_count) : bcd_dec(r_count);

    // Command arbitration (clear > load > stop > start) and prescaled stepping.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_presc_nxt = r_presc;
        w_done_nxt  = 1'b0;
        if (i_clear) begin
            w_count_nxt = 16'h0000;
            w_presc_nxt = 8'd0;
            w_state_nxt = IDLE;
        end else if (i_load && (r_state != RUN)) begin
            w_count_nxt = bcd_sat(i_load_val);
            w_presc_nxt = 8'd0;
            w_state_nxt = IDLE;
        end else if (i_stop && (r_state == RUN)) begin
            w_state_nxt = PAUSE;
        end else if (i_start && ((r_state == IDLE) || (r_state == PAUSE))
                     && (r_count != w_term)) begin
            w_state_nxt = RUN;
        end else if (r_state == RUN) begin
            if (r_presc == PRESC_MAX) begin
                w_presc_nxt = 8'd0;
                w_count_nxt = w_step_val;
                if (w_step_val == w_term) begin
                    w_state_nxt = DONE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_state_nxt = RUN;
                end
            end else begin
                w_presc_nxt = r_presc + 8'd1;
            end
        end else begin
            w_state_nxt = r_state;
        end
    end

    // Lap capture sees the pre-step count because it samples the current register.
    always_comb begin
`ifdef BCD_RUN_CTRL_LAP_EN
        if (i_lap && ((r_state == RUN) || (r_state == PAUSE))) begin
            w_lap_nxt = r_count;
        end else begin
            w_lap_nxt = r_lap_val;
        end
`else
        // lap has no effect in this build; the capture register stays zero.
        w_lap_nxt = 16'h0000 & {16{i_lap}};
`endif
    end

    // State, count, prescaler and registered status outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_count   <= 16'h0000;
            r_presc   <= 8'd0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
            r_lap_val <= 16'h0000;
        end else begin
            r_state   <= w_state_nxt;
            r_count   <= w_count_nxt;
            r_presc   <= w_presc_nxt;
            r_running <= (w_state_nxt == RUN);
            r_done    <= w_done_nxt;
            r_lap_val <= w_lap_nxt;
        end
    end

    assign o_count   = r_count;
    assign o_state   = r_state;
    assign o_running = r_running;
    assign o_done    = r_done;
    assign o_lap_val = r_lap_val;

endmodule

// File: tb/tb_bcd_run_ctrl.sv
// Directed self-checking bench for bcd_run_ctrl with TICK_DIV=4.
module tb_bcd_run_ctrl;

    logic        clk = 1'b0;
    logic        rst, start, stop, clear, load, up_dn, lap;
    logic [15:0] load_val;
    logic [15:0] count, lap_val;
    logic [1:0]  state;
    logic        running, done;
    int          checks = 0;
    int          failures = 0;

    bcd_run_ctrl #(.TICK_DIV(4)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_stop(stop),
        .i_clear(clear), .i_load(load), .i_load_val(load_val),
        .i_up_dn(up_dn), .i_lap(lap),
        .o_count(count), .o_state(state), .o_running(running),
        .o_done(done), .o_lap_val(lap_val)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(1); start = 1'b0;
    endtask

    task automatic do_load(input logic [15:0] v);
        load_val = v; load = 1'b1; tick(1); load = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0; load = 1'b0;
        up_dn = 1'b1; lap = 1'b0; load_val = 16'h0000;
        tick(2);
        rst = 1'b0;
        chk("rst_count", count, 16'h0000);
        chk("rst_state", {14'd0, state}, 16'h0000);
        chk("rst_running", {15'd0, running}, 16'h0000);
        chk("rst_done", {15'd0, done}, 16'h0000);
        chk("rst_lap", lap_val, 16'h0000);

        // Up count with carry
        pulse_start();
        chk("run_state", {14'd0, state}, 16'h0001);
        chk("run_running", {15'd0, running}, 16'h0001);
        tick(3);
        chk("up_before_first", count, 16'h0000);
        tick(1);
        chk("up_first", count, 16'h0001);
        tick(32);
        chk("up_0009", count, 16'h0009);
        tick(4);
        chk("up_0010", count, 16'h0010);

        // Pause at prescaler 2, resume
        tick(2);
        stop = 1'b1; tick(1); stop = 1'b0;
        chk("pause_state", {14'd0, state}, 16'h0002);
        chk("pause_running", {15'd0, running}, 16'h0000);
        tick(10);
        chk("pause_hold", count, 16'h0010);
        pulse_start();
        tick(1);
        chk("resume_wait", count, 16'h0010);
        tick(1);
        chk("resume_step", count, 16'h0011);

        // Lap at 0005, then same-cycle lap and step
        clear = 1'b1; tick(1); clear = 1'b0;
        pulse_start();
        tick(20);
        chk("lap_count", count, 16'h0005);
        lap = 1'b1; tick(1); lap = 1'b0;
`ifdef BCD_RUN_CTRL_LAP_EN
        chk("lap_capture", lap_val, 16'h0005);
`else
        chk("lap_disabled", lap_val, 16'h0000);
`endif
        tick(6);
        lap = 1'b1; tick(1); lap = 1'b0;
        chk("lap_step_count", count, 16'h0007);
`ifdef BCD_RUN_CTRL_LAP_EN
        chk("lap_pre_step", lap_val, 16'h0006);
`else
        chk("lap_disabled2", lap_val, 16'h0000);
`endif

        // clear beats start
        clear = 1'b1; start = 1'b1; tick(1); clear = 1'b0; start = 1'b0;
        chk("clr_start_count", count, 16'h0000);
        chk("clr_start_state", {14'd0, state}, 16'h0000);

        // Load saturation, load ignored in RUN
        do_load(16'h12A4);
        chk("load_sat", count, 16'h1294);
        chk("load_state", {14'd0, state}, 16'h0000);
        pulse_start();
        do_load(16'h0500);
        chk("load_in_run", count, 16'h1294);
        chk("load_in_run_state", {14'd0, state}, 16'h0001);
        clear = 1'b1; tick(1); clear = 1'b0;

        // Borrow
        up_dn = 1'b0;
        do_load(16'h0100);
        pulse_start();
        tick(3);
        chk("borrow_wait", count, 16'h0100);
        tick(1);
        chk("borrow", count, 16'h0099);

        // Terminal up
        clear = 1'b1; tick(1); clear = 1'b0;
        up_dn = 1'b1;
        do_load(16'h9997);
        pulse_start();
        tick(7);
        chk("term_pre", count, 16'h9998);
        chk("term_pre_done", {15'd0, done}, 16'h0000);
        tick(1);
        chk("term_count", count, 16'h9999);
        chk("term_state", {14'd0, state}, 16'h0003);
        chk("term_done", {15'd0, done}, 16'h0001);
        chk("term_running", {15'd0, running}, 16'h0000);
        tick(1);
        chk("term_done_once", {15'd0, done}, 16'h0000);
        tick(3);
        chk("term_hold", count, 16'h9999);
        pulse_start();
        chk("start_in_done", {14'd0, state}, 16'h0003);
        do_load(16'h9999);
        chk("load_from_done", {14'd0, state}, 16'h0000);
        pulse_start();
        chk("start_at_term", {14'd0, state}, 16'h0000);

        // Terminal down
        up_dn = 1'b0;
        do_load(16'h0002);
        pulse_start();
        tick(8);
        chk("down_term_count", count, 16'h0000);
        chk("down_term_done", {15'd0, done}, 16'h0001);

        // Reset mid-run aborts with no done
        up_dn = 1'b1;
        do_load(16'h9998);
        pulse_start();
        tick(3);
        rst = 1'b1; tick(1);
        chk("rst_mid_state", {14'd0, state}, 16'h0000);
        chk("rst_mid_count", count, 16'h0000);
        rst = 1'b0; tick(1);
        chk("rst_mid_done", {15'd0, done}, 16'h0000);
        chk("rst_mid_idle", {14'd0, state}, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
